// File: rtl/muller_c_pkg.sv
// Shared constants for the muller_c_proj C-element block: io_in pin indices
// and default parameter values for the synchroniser depth and counter width.
// Pure declarations; no logic, no latency, no flow control.
package muller_c_pkg;

    // io_in pin map
    localparam int CLR_BIT  = 0;
    localparam int HOLD_BIT = 1;
    localparam int C_BIT    = 2;
    localparam int A_BIT    = 3;
    localparam int B_BIT    = 4;
    localparam int CEN_BIT  = 5;

    localparam int IO_W = 6;

    // Defaults for the top-level parameters
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/muller_c_sync.sv
// Single-bit N-stage flop synchroniser, asynchronous active-low reset to 0.
// Latency: STAGES rising edges from d to q.
// No backpressure: samples every cycle.
//
// Ports: clk, rst_n, d (asynchronous input), q (synchronised output).
module muller_c_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    generate
        if (STAGES == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) chain <= '0;
                else        chain <= d;
            end
        end else begin : g_many
            // chain[0] is the metastability-catching flop, chain[STAGES-1] is used downstream
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) chain <= '0;
                else        chain <= {chain[STAGES-2:0], d};
            end
        end
    endgenerate

    assign q = chain[STAGES-1];

endmodule

// File: rtl/muller_c_proj_formal.sv
// Clocked Muller C-element on the muller_c_proj pin map, with output-transition counter.
// Latency: input change before edge k shows on y after edge k+SYNC_STAGES.
// No backpressure: inputs sampled every cycle; io_out is purely registered.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   io_in[5:0]          : {c_en, b, a, c, hold, clr}
//   io_out[5:0]         : {tog_cnt[3:0], y_n, y}
//   tog_cnt[CNT_W-1:0]  : count of y transitions, wraps, cleared only by rst_n
// Optional: define MULLER_C_FORMAL_EN to compile in the embedded asserts/covers.
// CNT_W must be at least 4 since io_out exposes tog_cnt[3:0].
module muller_c_proj_formal
    import muller_c_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       io_in,
    output logic [5:0]       io_out,
    output logic [CNT_W-1:0] tog_cnt
);

    logic [IO_W-1:0] io_sync;

    // Each pin gets its own chain; bits are not treated as a coherent bus.
    genvar gi;
    generate
        for (gi = 0; gi < IO_W; gi++) begin : g_sync
            muller_c_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (io_in[gi]),
                .q     (io_sync[gi])
            );
        end
    endgenerate

    logic clr, hold, in_a, in_b, in_c, c_en;
    assign clr  = io_sync[CLR_BIT];
    assign hold = io_sync[HOLD_BIT];
    assign in_c = io_sync[C_BIT];
    assign in_a = io_sync[A_BIT];
    assign in_b = io_sync[B_BIT];
    assign c_en = io_sync[CEN_BIT];

    // In 2-input mode c is masked so it never blocks consensus.
    logic all_one, all_zero;
    assign all_one  = in_a & in_b & (in_c | ~c_en);
    assign all_zero = ~in_a & ~in_b & (~in_c | ~c_en);

    logic y, y_next;

    always_comb begin
        y_next = y;
        if (clr) begin
            y_next = 1'b0;
        end else if (!hold) begin
            if (all_one)       y_next = 1'b1;
            else if (all_zero) y_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= 1'b0;
            tog_cnt <= '0;
        end else begin
            y <= y_next;
            // Counter moves on the same edge as y so both are always consistent.
            if (y_next != y) tog_cnt <= tog_cnt + 1'b1;
        end
    end

    assign io_out = {tog_cnt[3:0], ~y, y};

`ifdef MULLER_C_FORMAL_EN
    // y may only move when the synchronised inputs agree or clr is set.
    a_y_change_legal: assert property (@(posedge clk) disable iff (!rst_n)
        $changed(y) |-> ($past(clr) || ($past(!hold) && ($past(all_one) || $past(all_zero)))));

    a_y_n_inverse: assert property (@(posedge clk) disable iff (!rst_n)
        io_out[1] == ~io_out[0]);

    a_cnt_only_on_y: assert property (@(posedge clk) disable iff (!rst_n)
        $changed(tog_cnt) |-> $changed(y));

    c_y_rise: cover property (@(posedge clk) disable iff (!rst_n) $rose(y));
    c_y_fall: cover property (@(posedge clk) disable iff (!rst_n) $fell(y));
    c_cnt_wrap: cover property (@(posedge clk) disable iff (!rst_n)
        (tog_cnt == '0) && ($past(tog_cnt) == {CNT_W{1'b1}}));
    c_ab_two_input_rise: cover property (@(posedge clk) disable iff (!rst_n)
        (io_sync == 6'b011000) && !y ##1 y);
`endif

endmodule

// File: tb/tb_muller_c_proj_formal.sv
module tb_muller_c_proj_formal;

    localparam int SS = 2;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic [5:0]    io_in;
    logic [5:0]    io_out;
    logic [CW-1:0] tog_cnt;

    int tests;
    int fails;

    // Reference model: delay line of sampled pins plus C-element state
    logic [5:0] hist[$];
    logic       y_m;
    logic [CW-1:0] cnt_m;

    muller_c_proj_formal #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_in   (io_in),
        .io_out  (io_out),
        .tog_cnt (tog_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back(6'b000000);
        y_m   = 1'b0;
        cnt_m = '0;
    endtask

    // Apply the C-element rule to the pin vector that has just emerged from the delay line
    task automatic model_edge(input logic [5:0] v);
        int need, ones;
        logic ny;
        need = v[5] ? 3 : 2;
        ones = int'(v[3]) + int'(v[4]) + (v[5] ? int'(v[2]) : 0);
        ny = y_m;
        if (v[0])            ny = 1'b0;
        else if (!v[1]) begin
            if (ones == need) ny = 1'b1;
            else if (ones == 0) ny = 1'b0;
        end
        if (ny != y_m) cnt_m = cnt_m + 1'b1;
        y_m = ny;
    endtask

    // n clock edges; model updated at each edge, DUT checked 1 time unit after
    task automatic step(input int n);
        logic [5:0] used;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst_n) begin
                used = hist.pop_front();
                hist.push_back(io_in);
                model_edge(used);
            end
            #1;
            chk("io_out_model", {26'd0, io_out}, {26'd0, cnt_m[3:0], ~y_m, y_m});
            chk("tog_cnt_model", {24'd0, tog_cnt}, {24'd0, cnt_m});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset with all pins high
        rst_n = 1'b0;
        io_in = 6'b111111;
        model_reset();
        #1;
        chk("reset_io_out_async", {26'd0, io_out}, 32'h02);
        step(2);
        chk("reset_io_out", {26'd0, io_out}, 32'h02);
        chk("reset_tog_cnt", {24'd0, tog_cnt}, 32'd0);
        rst_n = 1'b1;

        // Rise in 2-input mode: exactly 3 edges
        io_in = 6'b011000;
        step(2);
        chk("rise_not_early", {31'd0, io_out[0]}, 32'd0);
        step(1);
        chk("rise_io_out_low", {30'd0, io_out[1:0]}, 32'h1);
        chk("rise_tog_cnt", {24'd0, tog_cnt}, 32'd1);

        // Disagreement holds state
        io_in = 6'b010000;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("hold_state_y", {31'd0, io_out[0]}, 32'd1);
        end
        io_in = 6'b000000;
        step(2);
        chk("fall_not_early", {31'd0, io_out[0]}, 32'd1);
        step(1);
        chk("fall_y", {31'd0, io_out[0]}, 32'd0);
        chk("fall_tog_cnt", {24'd0, tog_cnt}, 32'd2);

        // 3-input mode: c must agree
        io_in = 6'b111000;
        step(5);
        chk("three_in_c0_y", {31'd0, io_out[0]}, 32'd0);
        io_in = 6'b111100;
        step(2);
        chk("three_in_not_early", {31'd0, io_out[0]}, 32'd0);
        step(1);
        chk("three_in_rise", {31'd0, io_out[0]}, 32'd1);
        chk("three_in_tog_cnt", {24'd0, tog_cnt}, 32'd3);

        // clr beats hold
        io_in = 6'b011011;
        step(3);
        chk("clr_over_hold_y", {31'd0, io_out[0]}, 32'd0);
        chk("clr_tog_cnt", {24'd0, tog_cnt}, 32'd4);
        io_in = 6'b011010;
        step(6);
        chk("hold_blocks_rise", {31'd0, io_out[0]}, 32'd0);
        // Dropping hold lets the pending consensus through
        io_in = 6'b011000;
        step(3);
        chk("after_hold_rise", {31'd0, io_out[0]}, 32'd1);
        chk("after_hold_tog_cnt", {24'd0, tog_cnt}, 32'd5);

        // Glitch on a between edges must not be seen
        io_in = 6'b010000;
        step(1);
        io_in = 6'b000000;
        step(4);
        io_in = 6'b010000;
        step(4);
        #1 io_in = 6'b011000;
        #2 io_in = 6'b010000;
        step(5);
        chk("glitch_y", {31'd0, io_out[0]}, 32'd0);
        chk("glitch_tog_cnt", {24'd0, tog_cnt}, 32'd6);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                io_in = 6'($urandom);
                io_in[0] = ($urandom_range(0, 9) == 0);
                io_in[1] = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 1) == 1) begin
                    io_in[3] = io_in[4];
                    io_in[2] = io_in[4];
                end
            end
            step(1);
        end

        // Wrap: 256 transitions from a fresh reset
        rst_n = 1'b0;
        io_in = 6'b000000;
        model_reset();
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            io_in = (i % 2 == 0) ? 6'b011000 : 6'b000000;
            step(2);
        end
        step(4);
        chk("wrap_tog_cnt", {24'd0, tog_cnt}, 32'd0);
        chk("wrap_io_out_cnt", {28'd0, io_out[5:2]}, 32'd0);
        chk("wrap_y", {31'd0, io_out[0]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muller_c_proj_formal.md
Name: muller_c_proj_formal

Overview:
- Clocked, synchronised model of a Muller C-element, packaged for the muller_c_proj user-project pin map.
- Six-bit `io_in` bus: samples the C-element inputs through synchronisers, holds the C-element state in a register and counts output transitions.
- Drives a six-bit `io_out` bus.
- Serves as the formal/cover and simulation target for the asynchronous C-element macro.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser; legal range 1–4.
- CNT_W, 8, width of the output-transition counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- io_in  input  6  pin bus:
  - [0] clr: synchronous clear of the C-element state.
  - [1] hold: freeze the C-element state.
  - [2] c: third C-element input.
  - [3] a: first C-element input.
  - [4] b: second C-element input.
  - [5] c_en: when 1, `c` participates; when 0, 2-input mode.
- io_out  output  6  pin bus:
  - [0] y: C-element output.
  - [1] y_n: inverse of y.
  - [5:2] low 4 bits of the transition counter.
- tog_cnt  output  CNT_W  full output-transition counter; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All synchroniser flops, y, and tog_cnt go to 0.
  - io_out = 6'b000010 (y_n=1).
  - Release is synchronous to the next rising clk edge.
- Synchronisation:
  - Every io_in bit passes through an independent SYNC_STAGES-deep flop chain before use.
  - No combinational path from io_in to io_out.
- C-element rule, evaluated on synchronised values each cycle:
  - In 2-input mode (c_en=0): all of a,b = 1 → next y = 1; all = 0 → next y = 0; otherwise y holds.
  - In 3-input mode (c_en=1): same rule applied over a,b,c.
- Priority: clr > hold > C-element rule.
  - clr=1 forces y=0 regardless of other inputs.
  - hold=1 (with clr=0) keeps y unchanged.
- Latency: a stable input change present before rising edge k appears on y after edge k+SYNC_STAGES. With default SYNC_STAGES, that is 3 edges.
- tog_cnt:
  - Increments by 1 in the same cycle y changes value, including changes caused by clr.
  - Wraps from 2^CNT_W−1 to 0.
  - Not cleared by clr; cleared only by rst_n.
- Simultaneous events: an input change during hold is applied the cycle after hold drops, provided the inputs are still consensual.
- Glitch on a single input that settles back before synchronisation: no y change.

Optional Feature:
- Macro MULLER_C_FORMAL_EN.
- When defined, embedded properties are compiled in:
  - Asserts: y only changes when synchronised inputs agree or clr is set; y_n is always the inverse of y; tog_cnt changes only when y changes.
  - Covers: y rise, y fall, counter wrap, and the `io_in` pattern 6'b011000 (a=b=1, 2-input mode) driving y to 1.
- When undefined, no properties are present and RTL behaviour is identical.

Decomposition:
- Shared package muller_c_pkg:
  - io_in bit-index constants (CLR_BIT, HOLD_BIT, C_BIT, A_BIT, B_BIT, CEN_BIT).
  - Defaults for SYNC_STAGES and CNT_W.
- One sub-module, muller_c_sync: parameterised N-stage synchroniser with asynchronous active-low reset, instantiated per input bit.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with io_in=6'b111111 → io_out=6'b000010, tog_cnt=0; no change until release.
- Rise: io_in=6'b011000 after reset → y=1 exactly 3 edges later, io_out[1:0]=2'b01, tog_cnt=1.
- Hold state: from y=1, io_in=6'b010000 (a=0, b=1) → y stays 1 for 10 cycles; then 6'b000000 → y=0 after 3 edges, tog_cnt=2.
- 3-input mode: io_in=6'b111000 (c=0, c_en=1) → y stays 0; set c=1 (6'b111100) → y=1 after 3 edges.
- Clr/hold priority: with y=1, set io_in=6'b011011 (hold=1, clr=1) → y=0 after 3 edges; clear clr only (6'b011010) → y stays 0 while hold=1.
- Wrap: toggle a,b together 256 times → tog_cnt wraps to 0; io_out[5:2] tracks tog_cnt[3:0].
